branch_pc_ctrl: RTL
===================

# branch_pc_ctrl

Program-counter and branch-redirect stage that consumes the branch comparator's one-bit `bcres` verdict, together with decode-stage control-transfer information, and drives the instruction-fetch address. It resolves conditional branches, `j`/`jal`-style jumps and register jumps (`jr`) in decode. It computes 32-bit targets and holds a pending redirect when fetch back-pressures. It also handles the architectural branch delay slot, or squashes the fall-through instruction when the delay slot is configured off.

## Interface
- `RESET_PC`, default 32'h0000_0000, fetch address after reset.
- `DELAY_SLOT`, default 1. When 1, the instruction at branch PC+4 always executes. When 0, it is squashed on a taken transfer.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: hazard-unit freeze of fetch/decode.
- `ifetch_ready` in 1: instruction memory accepts `pc` this cycle.
- `is_branch` in 1: decode holds a conditional branch; taken iff `bcres`.
- `bcres` in 1: comparator verdict for the branch in decode.
- `is_jump` in 1: decode holds an absolute jump.
- `is_jr` in 1: decode holds a register jump.
- `branch_pc` in 32: PC of the instruction in decode.
- `br_offset` in 16: signed branch word offset.
- `jump_index` in 26: jump word index.
- `jr_target` in 32: forwarded register value for `jr`.
- `pc` out 32: current fetch address.
- `imem_req` out 1: fetch request. Equals `pc_valid & ~stall`.
- `flush` out 1: kill the instruction entering decode next cycle.
- `busy` out 1: redirect pending. The hazard unit must hold decode.
- `misalign` out 1: one-cycle pulse when a `jr` target has nonzero bits [1:0].

## Operation
- Internal state:
  - `pc` (32).
  - `pc_valid`.
  - `tgt` (32) pending target.
  - FSM {RUN, PEND}.
- Fetch accept = `imem_req & ifetch_ready`. In RUN with no redirect, accept advances `pc` by +4, wrapping modulo 2^32. Otherwise `pc` holds.
- Resolve inputs are sampled only in RUN with `stall`=0. In PEND, or while `stall`=1, they are ignored.
- A transfer is taken when `is_jr`, or `is_jump`, or (`is_branch & bcres`).
- Priority is `is_jr` > `is_jump` > `is_branch`. Multiple asserted is illegal, but the priority is defined.
- Targets (all arithmetic modulo 2^32):
  - Branch: `branch_pc + 4 + (sext(br_offset) << 2)`.
  - Jump: `{(branch_pc+4)[31:28], jump_index, 2'b00}`.
  - `jr`: `{jr_target[31:2], 2'b00}`. `misalign` pulses in the cycle after resolve if `jr_target[1:0] != 0`.
- A not-taken branch has no effect; sequential fetch continues.
- Taken transfer in cycle N, with `pc` = `branch_pc+4` (the delay slot / fall-through):
  - Accept in N, DELAY_SLOT=1: `pc` <= target at N+1. No flush.
  - Accept in N, DELAY_SLOT=0: `pc` <= target at N+1. `flush`=1 during N+1 only.
  - No accept in N, DELAY_SLOT=0: `pc` <= target at N+1, skipping fall-through. No flush.
  - No accept in N, DELAY_SLOT=1: `tgt` <= target, state -> PEND. `pc` holds `branch_pc+4`.
- PEND:
  - `busy`=1 (combinational on state).
  - On the first accept of `pc`, `pc` <= `tgt` and state -> RUN.
  - `stall` in PEND simply blocks the accept.

## Timing
- Reset (async assert): `pc`=RESET_PC, `pc_valid`=0, `imem_req`=0, `flush`=0, `busy`=0, `misalign`=0, state RUN, `tgt`=0.
- `pc_valid` rises on the first rising edge after `rst_n` deasserts. The first request for RESET_PC is in that cycle.
- Reset during PEND discards `tgt`. Fetch restarts at RESET_PC.
- Redirect latency is one cycle from resolve to the target appearing on `pc`. In PEND, it is one cycle after the delay-slot accept.
- `flush` and `misalign` are registered single-cycle pulses. They are never held across cycles.
- `busy` is 0 in the cycle the PEND->RUN transition is clocked in.
- While `stall`=1, the outputs `pc`, state and `tgt` are frozen. `flush`/`misalign` still deassert after one cycle.

## Test plan
- Reset: with RESET_PC=0x0000_0100, release `rst_n` then hold `ifetch_ready`=1 -> `pc` sequence 0x100, 0x104, 0x108; `imem_req` is 0 until the first edge after release.
- Taken branch: `branch_pc`=0x200, `br_offset`=0xFFFC, `bcres`=1, accept in N -> `pc`=0x1F4 at N+1. With DELAY_SLOT=0, additionally `flush`=1 at N+1 only. Same stimulus with `bcres`=0 -> `pc`=0x208.
- Back-pressure, DELAY_SLOT=1: taken jump, `jump_index`=0x0000040, `branch_pc`=0x1000, `ifetch_ready`=0 for 3 cycles -> `busy`=1 and `pc`=0x1004 held; first accept -> `pc`=0x0000_0100 next cycle, `busy`=0.
- Back-pressure, DELAY_SLOT=0: same stimulus -> `pc`=0x100 at N+1, `busy` stays 0, no flush.
- `jr` checks: `jr_target`=0x8000_0003 -> `pc`=0x8000_0000 and `misalign` pulses once. Wrap: `branch_pc`=0xFFFF_FFF8 with `br_offset`=1 -> target 0x0000_0000. Simultaneous `is_jr` + `is_branch` -> `jr` target wins.
- Stall/reset interplay: resolve inputs asserted under `stall`=1 -> no redirect. `rst_n` asserted while in PEND -> `pc`=RESET_PC, `busy`=0 immediately.

Source files
------------

// File: rtl/branch_pc_ctrl.sv
// branch_pc_ctrl
// Program-counter and branch-redirect stage. Resolves conditional branches,
// absolute jumps and register jumps in decode. Drives the fetch address,
// holds a pending redirect while fetch back-pressures, and handles the
// architectural delay slot (or squashes the fall-through when it is disabled).
//
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   stall           - hazard-unit freeze of fetch/decode
//   ifetch_ready    - instruction memory accepts pc this cycle
//   is_branch/bcres - conditional branch in decode and its comparator verdict
//   is_jump         - absolute jump in decode
//   is_jr           - register jump in decode
//   branch_pc       - PC of the instruction in decode
//   br_offset       - signed branch word offset
//   jump_index      - jump word index
//   jr_target       - forwarded register value for jr
//   pc              - current fetch address
//   imem_req        - fetch request (pc_valid & ~stall)
//   flush           - kill the instruction entering decode next cycle
//   busy            - redirect pending, decode must be held
//   misalign        - one-cycle pulse for a jr target with nonzero low bits
module branch_pc_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        ifetch_ready,
  input  logic        is_branch,
  input  logic        bcres,
  input  logic        is_jump,
  input  logic        is_jr,
  input  logic [31:0] branch_pc,
  input  logic [15:0] br_offset,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic        flush,
  output logic        busy,
  output logic        misalign
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic        pc_valid_q, pc_valid_d;
  logic        flush_q, flush_d;
  logic        misalign_q, misalign_d;

  logic        accept_s;
  logic        resolve_s;
  logic        taken_s;
  logic [31:0] target_s;

  // Redirect target selection; priority jr > jump > branch.
  function automatic logic [31:0] calc_target(
    input logic        f_is_jr,
    input logic        f_is_jump,
    input logic [31:0] f_branch_pc,
    input logic [15:0] f_br_offset,
    input logic [25:0] f_jump_index,
    input logic [31:0] f_jr_target
  );
    logic [31:0] seq_pc;
    logic [31:0] disp;
    seq_pc = f_branch_pc + 32'd4;
    disp   = {{14{f_br_offset[15]}}, f_br_offset, 2'b00};
    if (f_is_jr) begin
      calc_target = {f_jr_target[31:2], 2'b00};
    end else if (f_is_jump) begin
      calc_target = {seq_pc[31:28], f_jump_index, 2'b00};
    end else begin
      calc_target = seq_pc + disp;
    end
  endfunction

  assign imem_req  = pc_valid_q & ~stall;
  assign accept_s  = imem_req & ifetch_ready;
  // Decode information only counts while running and not frozen.
  assign resolve_s = (state_q == ST_RUN) & ~stall;
  assign taken_s   = resolve_s & (is_jr | is_jump | (is_branch & bcres));
  assign target_s  = calc_target(is_jr, is_jump, branch_pc, br_offset,
                                 jump_index, jr_target);

  assign pc       = pc_q;
  assign busy     = (state_q == ST_PEND);
  assign flush    = flush_q;
  assign misalign = misalign_q;

  // Next-state and next-pc logic for the redirect FSM.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    pc_valid_d = 1'b1;
    flush_d    = 1'b0;
    misalign_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (taken_s) begin
          misalign_d = is_jr & (jr_target[1:0] != 2'b00);
          if (accept_s) begin
            // Fall-through was fetched; squash it only without a delay slot.
            pc_d    = target_s;
            flush_d = (DELAY_SLOT == 1'b0);
          end else if (DELAY_SLOT == 1'b0) begin
            // Fall-through never fetched: jump straight over it.
            pc_d = target_s;
          end else begin
            // Delay slot must still be fetched before the redirect.
            tgt_d   = target_s;
            state_d = ST_PEND;
          end
        end else if (accept_s) begin
          pc_d = pc_q + 32'd4;
        end else begin
          pc_d = pc_q;
        end
      end
      ST_PEND: begin
        if (accept_s) begin
          pc_d    = tgt_q;
          state_d = ST_RUN;
        end else begin
          state_d = ST_PEND;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      tgt_q      <= 32'h0000_0000;
      pc_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      pc_valid_q <= pc_valid_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
    end
  end

endmodule
